// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth sequencer: FSM state encoding and Booth recode values.
package booth_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, EVAL, SHIFT, DONE} booth_state_t;

    // {LQ[0], Q_1} codes that call for an add or a subtract of M into HQ
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_iter_cnt.sv
// Iteration counter for the Booth sequencer: synchronous clear, increment, and last-iteration flag.
module booth_iter_cnt #(
    parameter int N     = 12,
    parameter int CNT_W = $clog2(N+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (inc)  cnt <= cnt + CNT_W'(1);
    end

    assign last = (cnt == CNT_W'(N-1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for the radix-2 Booth shift/add datapath; strobes are Moore decodes of state.
// Optional BOOTH_CTRL_FASTSKIP_EN: 00/11 recode iterations shift straight from EVAL in one cycle.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N     = 12,
    parameter int CNT_W = $clog2(N+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           abort,
    output logic           dp_clr_n,
    output logic [N-1:0]   dp_a,
    output logic [N-1:0]   dp_b,
    output logic           load_A,
    output logic           load_B,
    output logic           load_add,
    output logic           shift_HQ_LQ_Q_1,
    output logic           add_sub,
    input  logic [1:0]     Q_LSB,
    input  logic [2*N-1:0] dp_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    booth_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             recode_op;

    assign recode_op = (Q_LSB == BOOTH_ADD) || (Q_LSB == BOOTH_SUB);

    booth_iter_cnt #(.N(N), .CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == LOAD),
        .inc  (shift_HQ_LQ_Q_1),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start_valid) state_d = CLEAR;
                CLEAR: state_d = LOAD;
                LOAD:  state_d = EVAL;
                EVAL: begin
`ifdef BOOTH_CTRL_FASTSKIP_EN
                    if (recode_op)     state_d = SHIFT;
                    else if (cnt_last) state_d = DONE;
                    else               state_d = EVAL;
`else
                    state_d = SHIFT;
`endif
                end
                SHIFT: state_d = cnt_last ? DONE : EVAL;
                DONE:  if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready     = 1'b0;
        load_A          = 1'b0;
        load_B          = 1'b0;
        load_add        = 1'b0;
        add_sub         = 1'b0;
        shift_HQ_LQ_Q_1 = 1'b0;
        out_valid       = 1'b0;
        case (state_q)
            IDLE: start_ready = 1'b1;
            LOAD: begin
                load_A = 1'b1;
                load_B = 1'b1;
            end
            EVAL: begin
                if (Q_LSB == BOOTH_ADD) begin
                    load_add = 1'b1;
                    add_sub  = 1'b1;
                end else if (Q_LSB == BOOTH_SUB) begin
                    load_add = 1'b1;
                end else begin
`ifdef BOOTH_CTRL_FASTSKIP_EN
                    shift_HQ_LQ_Q_1 = 1'b1;
`endif
                end
            end
            SHIFT: shift_HQ_LQ_Q_1 = 1'b1;
            DONE:  out_valid       = 1'b1;
            default: ;
        endcase
    end

    // dp_clr_n is registered from the next state so the datapath sees a glitch-free clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_clr_n <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
        end else begin
            dp_clr_n <= (state_d != CLEAR);
            if (state_q == IDLE && start_valid && !abort) begin
                dp_a <= in_a;
                dp_b <= in_b;
            end
        end
    end

    assign product = dp_y;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl with a behavioural Booth datapath and a per-cycle reference model.
module tb_booth_seq_ctrl;
    localparam int N = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [N-1:0]   in_a = '0, in_b = '0;
    logic           start_ready, dp_clr_n, load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub, out_valid;
    logic [N-1:0]   dp_a, dp_b;
    logic [1:0]     Q_LSB;
    logic [2*N-1:0] dp_y, product;

    int tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .in_a(in_a), .in_b(in_b), .abort(abort), .dp_clr_n(dp_clr_n),
        .dp_a(dp_a), .dp_b(dp_b), .load_A(load_A), .load_B(load_B), .load_add(load_add),
        .shift_HQ_LQ_Q_1(shift_HQ_LQ_Q_1), .add_sub(add_sub), .Q_LSB(Q_LSB), .dp_y(dp_y),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    // Datapath: HQ carries one guard bit so -2^(N-1) operands stay exact
    logic [N:0]   hq, m;
    logic [N-1:0] lq;
    logic         q1;
    always @(posedge clk) begin
        if (!dp_clr_n) begin
            hq <= '0; m <= '0; lq <= '0; q1 <= 1'b0;
        end else begin
            if (load_A) m <= {dp_a[N-1], dp_a};
            if (load_B) begin lq <= dp_b; q1 <= 1'b0; end
            if (load_add) hq <= add_sub ? hq + m : hq - m;
            if (shift_HQ_LQ_Q_1) {hq, lq, q1} <= {hq[N], hq, lq};
        end
    end
    assign Q_LSB = {lq[0], q1};
    assign dp_y  = {hq[N-1:0], lq};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int n_ops(input logic [N-1:0] b);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (b[i] != prev) n++;
            prev = b[i];
        end
        return n;
    endfunction

    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef BOOTH_CTRL_FASTSKIP_EN
        return 3 + N + n_ops(b);
`else
        return 3 + 2*N;
`endif
    endfunction

    function automatic logic [2*N-1:0] exp_prod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [N-1:0]   sa, sb;
        logic signed [2*N-1:0] p;
        sa = a; sb = b;
        p  = sa * sb;
        return p;
    endfunction

    // Reference model: 0 idle, 1 computing, 2 product presented
    int ph = 0, acc = 0, due = 0, nadd = 0, exp_nadd = 0, nstb;
    logic [2*N-1:0] exp_p;
    always @(negedge clk) begin
        if (!rst) begin
            ph = 0;
        end else begin
            if (ph == 1 && cyc == due) begin
                chk("load_add_pulses", nadd, exp_nadd);
                ph = 2;
            end
            nstb = int'(load_A) + int'(load_B) + int'(load_add) + int'(shift_HQ_LQ_Q_1);
            chk("strobe_onehot", (nstb <= 1) || (load_A && load_B && nstb == 2), 1);
            chk("add_shift_excl", load_add && shift_HQ_LQ_Q_1, 0);
            case (ph)
                0: begin
                    chk("idle_ready", start_ready, 1);
                    chk("idle_valid", out_valid, 0);
                    chk("idle_strobes", nstb, 0);
                end
                1: begin
                    chk("busy_ready", start_ready, 0);
                    chk("busy_valid", out_valid, 0);
                    if (cyc == acc + 1) chk("clear_cycle", dp_clr_n, 0);
                    else                chk("clr_high", dp_clr_n, 1);
                    if (cyc == acc + 2) chk("load_ab", load_A && load_B, 1);
                    else                chk("no_load_ab", load_A || load_B, 0);
                    if (load_add) nadd++;
                end
                default: begin
                    chk("done_valid", out_valid, 1);
                    chk("done_ready", start_ready, 0);
                    chk("product", product, exp_p);
                    chk("done_strobes", nstb, 0);
                end
            endcase
            if (abort) ph = 0;
            else if (ph == 0 && start_valid) begin
                acc = cyc; due = cyc + exp_lat(in_b); exp_p = exp_prod(in_a, in_b);
                exp_nadd = n_ops(in_b); nadd = 0; ph = 1;
            end else if (ph == 2 && out_ready) ph = 0;
        end
    end

    task automatic start_only(input logic [N-1:0] a, input logic [N-1:0] b, output int t0);
        int k = 0;
        while (!start_ready && k < 200) begin @(posedge clk); #1; k++; end
        if (k >= 200) chk("start_timeout", 0, 1);
        start_valid = 1'b1; in_a = a; in_b = b;
        t0 = cyc;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                           output logic [2*N-1:0] p, output int lat, output int t0);
        int k = 0;
        start_only(a, b, t0);
        while (!out_valid && k < 200) begin @(posedge clk); #1; k++; end
        if (k >= 200) chk("valid_timeout", 0, 1);
        lat = cyc - t0;
        p = product;
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_product", product, p);
            chk("hold_strobes", {load_A, load_B, load_add, shift_HQ_LQ_Q_1}, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2*N-1:0] p;
        logic [N-1:0]   a, b, prev_a;
        int lat, t0, t1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_strobes", {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}, 0);
        chk("rst_clr_n", dp_clr_n, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_txn(12'd3, 12'd5, 0, p, lat, t0);
        chk("p_3x5", p, 24'h00000F);
`ifdef BOOTH_CTRL_FASTSKIP_EN
        chk("lat_3x5", lat, 19);
`else
        chk("lat_3x5", lat, 27);
`endif
        run_txn(12'hFFD, 12'd5, 0, p, lat, t0);
        chk("p_m3x5", p, 24'hFFFFF1);
        run_txn(12'h800, 12'h800, 0, p, lat, t0);
        chk("p_min_min", p, 24'h400000);
        run_txn(12'h7FF, 12'h800, 0, p, lat, t0);
        chk("p_max_min", p, 24'hC00800);

        // back-to-back with immediate acceptance of the product
        run_txn(12'd7, 12'd7, 0, p, lat, t0);
        chk("p_7x7", p, 24'h000031);
        run_txn(12'd1, 12'd1, 0, p, lat, t1);
        chk("p_1x1", p, 24'h000001);
`ifdef BOOTH_CTRL_FASTSKIP_EN
        chk("b2b_period", t1 - t0, 18);
`else
        chk("b2b_period", t1 - t0, 28);
`endif

        run_txn(12'd9, 12'hFF6, 5, p, lat, t0);
        chk("p_9xm10", p, 24'hFFFFA6);
        chk("idle_after_hold", start_ready, 1);

        // abort during the third EVAL
        start_only(12'd11, 12'd13, t0);
        while (cyc < t0 + 7) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", start_ready, 1);
        for (int i = 0; i < 40; i++) begin
            chk("abort_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        run_txn(12'd2, 12'd3, 0, p, lat, t0);
        chk("p_2x3", p, 24'h000006);

        // abort wins over start_valid in IDLE
        prev_a = dp_a;
        start_valid = 1'b1; abort = 1'b1; in_a = 12'h123; in_b = 12'h456;
        @(posedge clk); #1;
        start_valid = 1'b0; abort = 1'b0;
        chk("abort_idle_capture", dp_a, prev_a);
        chk("abort_idle_ready", start_ready, 1);

        // asynchronous reset while in SHIFT
        start_only(12'd5, 12'd3, t0);
        while (cyc < t0 + 4) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_strobes", {load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub}, 0);
        chk("arst_clr_n", dp_clr_n, 0);
        chk("arst_dp_ab", {dp_a, dp_b}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk("arst_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end

`ifdef BOOTH_CTRL_FASTSKIP_EN
        run_txn(12'd0, 12'd0, 0, p, lat, t0);
        chk("fs_lat_0x0", lat, 15);
        chk("fs_p_0x0", p, 24'h000000);
        run_txn(12'hFFF, 12'd1, 0, p, lat, t0);
        chk("fs_p_m1x1", p, 24'hFFFFFF);
`endif

        for (int i = 0; i < 30; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if (i % 7 == 0) a = 12'h800;
            if (i % 5 == 0) b = 12'hFFF;
            run_txn(a, b, $urandom_range(0, 3), p, lat, t0);
            chk("rand_lat", lat, exp_lat(b));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
